// File: rtl/lsu_mem_port_if.sv
// LSU memory-port bundle: scheduler request, RMW write-back, memory bus and load return.
// slave modport is the LSU side; master modport is the environment (scheduler/RMW/memory).
// Widths follow ADDR_W/DATA_W; keep them equal to the LSU instance parameters.
interface lsu_mem_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              sched_valid;
  logic              sched_store;
  logic [ADDR_W-1:0] sched_addr;
  logic [DATA_W-1:0] sched_data;
  logic              sched_ack;
  logic              rmw_rdy;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_data;
  logic              rmw_deny;
  logic              rmw_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] load_data;
  logic              load_rdy;
  logic              bus_err;

  modport slave (
    input  sched_valid, sched_store, sched_addr, sched_data,
    input  rmw_rdy, rmw_addr, rmw_data, rmw_deny,
    input  mem_ack, mem_data_in,
    output sched_ack, rmw_ack, mem_addr, mem_data_out, mem_rd, mem_wr,
    output load_data, load_rdy, bus_err
  );

  modport master (
    output sched_valid, sched_store, sched_addr, sched_data,
    output rmw_rdy, rmw_addr, rmw_data, rmw_deny,
    output mem_ack, mem_data_in,
    input  sched_ack, rmw_ack, mem_addr, mem_data_out, mem_rd, mem_wr,
    input  load_data, load_rdy, bus_err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// LSU memory port: arbitrates scheduler loads/stores vs RMW write-backs onto one req/ack bus.
// Latency: accept N, bus request N+1, mem_ack at N+1 -> load_rdy/rmw_ack at N+2 (2 cycles/op).
// Backpressure: sched_ack withheld while busy, while rmw_rdy wins, or while rmw_deny; optional
// bus timeout enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         a_rst,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RMW_WR} state_t;

  state_t state, state_nxt;
  logic   take_rmw, take_sched, xfer_done, xfer_abort;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // State register; async reset drops any bus request immediately.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and arbitration: RMW wins ties, deny only blocks the scheduler.
  always_comb begin
    state_nxt  = state;
    take_rmw   = 1'b0;
    take_sched = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rmw_rdy) begin
          take_rmw  = 1'b1;
          state_nxt = RMW_WR;
        end else if (bus.sched_valid && !bus.rmw_deny) begin
          take_sched = 1'b1;
          state_nxt  = bus.sched_store ? WR : RD;
        end
      end
      default: begin
        if (bus.mem_ack) begin
          xfer_done = 1'b1;
          state_nxt = IDLE;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          xfer_abort = 1'b1;
          state_nxt  = IDLE;
        end
`endif
      end
    endcase
  end

  assign bus.sched_ack = take_sched;
  assign bus.mem_rd    = (state == RD);
  assign bus.mem_wr    = (state == WR) || (state == RMW_WR);

  // Capture bus address/data at accept so they stay stable for the whole transfer.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
    end else if (take_rmw) begin
      bus.mem_addr     <= bus.rmw_addr;
      bus.mem_data_out <= bus.rmw_data;
    end else if (take_sched) begin
      bus.mem_addr     <= bus.sched_addr;
      bus.mem_data_out <= bus.sched_data;
    end
  end

  // Completion pulses; an aborted load returns all-ones so the consumer still gets a result.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      bus.load_rdy  <= 1'b0;
      bus.rmw_ack   <= 1'b0;
      bus.load_data <= '0;
    end else begin
      bus.load_rdy <= (state == RD) && (xfer_done || xfer_abort);
      bus.rmw_ack  <= (state == RMW_WR) && (xfer_done || xfer_abort);
      if (state == RD && xfer_done)
        bus.load_data <= bus.mem_data_in;
      else if (state == RD && xfer_abort)
        bus.load_data <= '1;
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  // Wait counter: zero on the first busy cycle, counts cycles spent without mem_ack.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)              tmo_cnt <= '0;
    else if (state == IDLE) tmo_cnt <= '0;
    else if (!bus.mem_ack)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Bus error pulse the cycle after the wait budget is exhausted.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) bus.bus_err <= 1'b0;
    else       bus.bus_err <= xfer_abort;
  end
`else
  assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: table of single transactions plus hand-written
// sequences for arbitration ties, deny blocking, stray mem_ack and mid-transfer reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled 3 units later.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic a_rst = 1'b1;
  int   checks = 0;
  int   fails = 0;

  lsu_mem_port_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lsu_mem_port #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rmw;
    logic        store;
    logic [15:0] addr;
    logic [15:0] data;
    int          wait_cyc;
    logic [15:0] rd_data;
    logic        exp_ack;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_load_rdy;
    logic        exp_rmw_ack;
    logic [15:0] exp_load_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    step();
    if (v.is_rmw) begin
      bus.rmw_rdy  = 1'b1;
      bus.rmw_addr = v.addr;
      bus.rmw_data = v.data;
    end else begin
      bus.sched_valid = 1'b1;
      bus.sched_store = v.store;
      bus.sched_addr  = v.addr;
      bus.sched_data  = v.data;
    end
    settle();
    chk($sformatf("v%0d accept sched_ack", idx), bus.sched_ack, v.exp_ack);
    chk($sformatf("v%0d accept bus idle", idx), {bus.mem_rd, bus.mem_wr}, 0);
    for (int c = 0; c <= v.wait_cyc; c++) begin
      step();
      bus.sched_valid = 1'b0;
      if (c == v.wait_cyc) begin
        bus.mem_ack     = 1'b1;
        bus.mem_data_in = v.rd_data;
      end
      settle();
      chk($sformatf("v%0d c%0d mem_rd", idx, c), bus.mem_rd, v.exp_rd);
      chk($sformatf("v%0d c%0d mem_wr", idx, c), bus.mem_wr, v.exp_wr);
      chk($sformatf("v%0d c%0d mem_addr", idx, c), bus.mem_addr, v.addr);
      if (v.exp_wr) chk($sformatf("v%0d c%0d mem_data_out", idx, c), bus.mem_data_out, v.data);
      chk($sformatf("v%0d c%0d no pulse while busy", idx, c), {bus.load_rdy, bus.rmw_ack}, 0);
    end
    step();
    bus.mem_ack = 1'b0;
    bus.rmw_rdy = 1'b0;
    settle();
    chk($sformatf("v%0d resp load_rdy", idx), bus.load_rdy, v.exp_load_rdy);
    chk($sformatf("v%0d resp rmw_ack", idx), bus.rmw_ack, v.exp_rmw_ack);
    chk($sformatf("v%0d resp load_data", idx), bus.load_data, v.exp_load_data);
    chk($sformatf("v%0d resp bus_err", idx), bus.bus_err, 0);
    chk($sformatf("v%0d resp bus released", idx), {bus.mem_rd, bus.mem_wr}, 0);
    step();
    settle();
    chk($sformatf("v%0d pulses end", idx), {bus.load_rdy, bus.rmw_ack}, 0);
  endtask

  vec_t vecs[6];

  initial begin
    //            rmw   st    addr      data      wt rd_data   ack   rd    wr    lrdy  rack  load_data
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 16'h5A5A, 3, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0001, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5C3};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 0, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5C3};

    bus.sched_valid = 1'b0;
    bus.sched_store = 1'b0;
    bus.sched_addr  = '0;
    bus.sched_data  = '0;
    bus.rmw_rdy     = 1'b0;
    bus.rmw_addr    = '0;
    bus.rmw_data    = '0;
    bus.rmw_deny    = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_data_in = '0;

    // Reset state
    #2;
    chk("reset strobes", {bus.mem_rd, bus.mem_wr, bus.load_rdy, bus.rmw_ack, bus.bus_err, bus.sched_ack}, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_data_out", bus.mem_data_out, 0);
    chk("reset load_data", bus.load_data, 0);
    step();
    step();
    a_rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Tie: RMW beats scheduler, scheduler accepted in the rmw_ack cycle
    step();
    bus.rmw_rdy = 1'b1; bus.rmw_addr = 16'h0010; bus.rmw_data = 16'h0001;
    bus.sched_valid = 1'b1; bus.sched_store = 1'b0; bus.sched_addr = 16'h2222;
    settle();
    chk("tie sched_ack", bus.sched_ack, 0);
    step();
    bus.mem_ack = 1'b1;
    settle();
    chk("tie rmw mem_wr", {bus.mem_wr, bus.mem_rd}, 2'b10);
    chk("tie rmw mem_addr", bus.mem_addr, 16'h0010);
    chk("tie rmw mem_data_out", bus.mem_data_out, 16'h0001);
    chk("tie busy sched_ack", bus.sched_ack, 0);
    step();
    bus.mem_ack = 1'b0; bus.rmw_rdy = 1'b0;
    settle();
    chk("tie rmw_ack", bus.rmw_ack, 1);
    chk("tie back-to-back sched_ack", bus.sched_ack, 1);
    step();
    bus.sched_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_data_in = 16'h7777;
    settle();
    chk("tie load mem_rd", bus.mem_rd, 1);
    chk("tie load mem_addr", bus.mem_addr, 16'h2222);
    chk("tie rmw_ack single pulse", bus.rmw_ack, 0);
    step();
    bus.mem_ack = 1'b0;
    settle();
    chk("tie load_rdy", bus.load_rdy, 1);
    chk("tie load_data", bus.load_data, 16'h7777);

    // Deny holds off the scheduler for 5 cycles
    step();
    bus.sched_valid = 1'b1; bus.sched_store = 1'b0; bus.sched_addr = 16'h3333; bus.rmw_deny = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("deny c%0d sched_ack", c), bus.sched_ack, 0);
      chk($sformatf("deny c%0d bus idle", c), {bus.mem_rd, bus.mem_wr}, 0);
      step();
    end
    bus.rmw_deny = 1'b0;
    settle();
    chk("deny release sched_ack", bus.sched_ack, 1);
    step();
    bus.sched_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_data_in = 16'h0BAD;
    settle();
    chk("deny mem_rd", bus.mem_rd, 1);
    chk("deny mem_addr", bus.mem_addr, 16'h3333);
    step();
    bus.mem_ack = 1'b0;
    settle();
    chk("deny load_data", bus.load_data, 16'h0BAD);

    // Stray mem_ack in IDLE is ignored
    step();
    bus.mem_ack = 1'b1; bus.mem_data_in = 16'hDEAD;
    step();
    bus.mem_ack = 1'b0;
    settle();
    chk("idle ack no pulse", {bus.load_rdy, bus.rmw_ack, bus.mem_rd, bus.mem_wr}, 0);
    chk("idle ack load_data kept", bus.load_data, 16'h0BAD);

    // Reset during RD drops mem_rd at once, no load_rdy
    step();
    bus.sched_valid = 1'b1; bus.sched_store = 1'b0; bus.sched_addr = 16'h4444;
    step();
    bus.sched_valid = 1'b0;
    settle();
    chk("rst pre mem_rd", bus.mem_rd, 1);
    a_rst = 1'b1;
    #1;
    chk("rst mem_rd drop", bus.mem_rd, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    step();
    a_rst = 1'b0;
    settle();
    chk("rst after no load_rdy", {bus.load_rdy, bus.mem_rd}, 0);
    step();
    bus.sched_valid = 1'b1; bus.sched_addr = 16'h5555;
    settle();
    chk("rst idle accept", bus.sched_ack, 1);
    step();
    bus.sched_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_data_in = 16'h5A5A;
    step();
    bus.mem_ack = 1'b0;
    settle();
    chk("rst post load_data", bus.load_data, 16'h5A5A);

`ifdef LSU_BUS_TIMEOUT_EN
    // Load with no mem_ack times out after 4 cycles
    step();
    bus.sched_valid = 1'b1; bus.sched_addr = 16'h6666;
    for (int c = 0; c < 4; c++) begin
      step();
      bus.sched_valid = 1'b0;
      settle();
      chk($sformatf("tmo c%0d mem_rd", c), bus.mem_rd, 1);
    end
    step();
    settle();
    chk("tmo bus_err", bus.bus_err, 1);
    chk("tmo load_rdy", bus.load_rdy, 1);
    chk("tmo load_data", bus.load_data, 16'hFFFF);
    chk("tmo mem_rd released", bus.mem_rd, 0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
